// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the static-pipeline MIPS CPU.
// Owns the PC, issues one word request at a time to instruction memory,
// buffers returned words in a small FIFO and hands {pc, instr} bundles to
// IF/ID under a valid/ready handshake. Redirects flush the FIFO and any
// in-flight fetch is dropped when its ack finally arrives.
// Optional feature: define IF_ADEL_EN to add id_adel, which reports a
// misaligned redirect target as a single address-error bundle.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
`ifdef IF_ADEL_EN
  output logic        id_adel,
`endif
  input  logic        id_ready
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [PW-1:0] LAST  = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);

  // PARK is only entered after a misaligned redirect with IF_ADEL_EN.
  typedef enum logic [1:0] {IDLE, REQ, DROP, PARK} state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    reqAddr_q, reqAddr_d;
  logic           park_q, park_d;
  logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d, wrIdx;
  logic [CW-1:0]  count_q, count_d;
  logic           wrEn;
  logic [31:0]    wrPc, wrInstr;
  logic           pop, ack, adelHit;
  logic [31:0]    pcMem_q    [BUF_DEPTH];
  logic [31:0]    instrMem_q [BUF_DEPTH];
`ifdef IF_ADEL_EN
  logic           adelMem_q  [BUF_DEPTH];
`endif

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr = reqAddr_q;
  assign id_valid  = (count_q != '0);
  assign id_pc     = pcMem_q[rd_q];
  assign id_instr  = instrMem_q[rd_q];
  assign ack       = imem_req && imem_ack;
  assign pop       = id_valid && id_ready;

`ifdef IF_ADEL_EN
  assign id_adel = adelMem_q[rd_q];
  assign adelHit = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign adelHit = 1'b0;
`endif

  // Next-state: redirect wins, otherwise fetch whenever the FIFO has room.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    park_d  = park_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    wrEn    = 1'b0;
    wrIdx   = wr_q;
    wrPc    = pc_q;
    wrInstr = imem_rdata;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      park_d  = adelHit;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      if (adelHit) begin
        wrEn    = 1'b1;
        wrIdx   = '0;
        wrPc    = redirect_pc;
        wrInstr = '0;
        wr_d    = PW'(1);
        count_d = CW'(1);
      end
      if (imem_req && !imem_ack) begin
        state_d = DROP;
      end else if (adelHit) begin
        state_d = PARK;
      end else begin
        state_d = REQ;
      end
    end else begin
      if (pop) begin
        rd_d = bump(rd_q);
      end
      if (ack && state_q == REQ) begin
        wrEn = 1'b1;
        wr_d = bump(wr_q);
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + CW'(wrEn) - CW'(pop);
      case (state_q)
        IDLE, REQ: begin
          if (state_q == IDLE || ack) begin
            state_d = (count_d < DEPTH) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (ack) begin
            state_d = park_q ? PARK : REQ;
          end
        end
        default: state_d = state_q;
      endcase
    end
    reqAddr_d = (state_d == DROP) ? reqAddr_q : pc_d;
  end

  // Control registers: FSM state, PC, held request address, FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      reqAddr_q <= RESET_PC;
      park_q    <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reqAddr_q <= reqAddr_d;
      park_q    <= park_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the idle id_pc/id_instr read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pcMem_q[i]    <= '0;
        instrMem_q[i] <= '0;
`ifdef IF_ADEL_EN
        adelMem_q[i]  <= 1'b0;
`endif
      end
    end else if (wrEn) begin
      pcMem_q[wrIdx]    <= wrPc;
      instrMem_q[wrIdx] <= wrInstr;
`ifdef IF_ADEL_EN
      adelMem_q[wrIdx]  <= redirect_valid;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized bench for if_fetch_unit. The bench plays the
// instruction memory and keeps a transaction-level model: a queue of the
// bundles that should be visible to ID, the next fetch address, and whether
// an in-flight fetch has become stale.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready = 1'b0;
`ifdef IF_ADEL_EN
  logic        id_adel;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } bundle_t;

  bundle_t     expQ[$];
  logic [31:0] modelPc;
  logic [31:0] staleAddr;
  bit          stale;
  bit          parked;
  bit          expReq;
  int          memWait;
  int          curLat;
  int          latMin;
  int          latMax;
  int          checkCount = 0;
  int          passCount = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
`ifdef IF_ADEL_EN
    .id_adel        (id_adel),
`endif
    .id_ready       (id_ready)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic setLatency(input int lo, input int hi);
    latMin = lo;
    latMax = hi;
    curLat = $urandom_range(hi, lo);
  endtask

  task automatic resetModel();
    expQ.delete();
    modelPc   = RESET_PC;
    staleAddr = '0;
    stale     = 1'b0;
    parked    = 1'b0;
    expReq    = 1'b0;
    memWait   = 0;
  endtask

  // Holds reset for two cycles, checks the reset values, releases on a negedge.
  task automatic doReset();
    rst            = 1'b1;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_pc", id_pc, 32'd0);
    checkOutput("rst_instr", id_instr, 32'd0);
`ifdef IF_ADEL_EN
    checkOutput("rst_adel", 32'(id_adel), 32'd0);
`endif
    rst = 1'b0;
    resetModel();
  endtask

  // One clock: compare outputs with the model, answer as memory, advance the model.
  task automatic applyStimulus(input bit ready, input bit redir, input logic [31:0] target);
    bit          ack;
    bit          ackM;
    bit          mReq;
    bit          pop;
    logic [31:0] rdata;
    bundle_t     b;
    checkOutput("imem_req", 32'(imem_req), 32'(expReq));
    if (imem_req && expReq) begin
      checkOutput("imem_addr", imem_addr, stale ? staleAddr : modelPc);
    end
    checkOutput("id_valid", 32'(id_valid), 32'(expQ.size() != 0));
    if (id_valid && expQ.size() != 0) begin
      checkOutput("id_pc", id_pc, expQ[0].pc);
      checkOutput("id_instr", id_instr, expQ[0].instr);
`ifdef IF_ADEL_EN
      checkOutput("id_adel", 32'(id_adel), 32'(expQ[0].adel));
`endif
    end
    ack   = imem_req && (memWait >= curLat);
    rdata = $urandom;
    imem_ack       = ack;
    imem_rdata     = rdata;
    id_ready       = ready;
    redirect_valid = redir;
    redirect_pc    = target;

    mReq = expReq;
    ackM = mReq && ack;
    pop  = (expQ.size() != 0) && ready;
    if (redir) begin
      if (mReq && !ackM) begin
        if (!stale) staleAddr = modelPc;
        stale = 1'b1;
      end else begin
        stale = 1'b0;
      end
      expQ.delete();
      parked = 1'b0;
`ifdef IF_ADEL_EN
      if (target[1:0] != 2'b00) begin
        b.pc    = target;
        b.instr = 32'd0;
        b.adel  = 1'b1;
        expQ.push_back(b);
        parked = 1'b1;
      end
`endif
      modelPc = target & 32'hFFFF_FFFC;
      expReq  = stale ? 1'b1 : !parked;
    end else begin
      if (pop) void'(expQ.pop_front());
      if (ackM) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          b.pc    = modelPc;
          b.instr = rdata;
          b.adel  = 1'b0;
          expQ.push_back(b);
          modelPc = modelPc + 32'd4;
        end
      end
      if (mReq && !ackM) expReq = 1'b1;
      else if (parked) expReq = 1'b0;
      else expReq = (expQ.size() < DEPTH);
    end

    if (imem_req && !ack) memWait++;
    else memWait = 0;
    if (ack) curLat = $urandom_range(latMax, latMin);
    @(posedge clk);
    @(negedge clk);
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    bit          found;
    bit          r;
    logic [31:0] tgt;
    resetModel();
    setLatency(0, 0);

    // Zero-wait memory, always ready: one instruction per cycle from 0x3000.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Stalled consumer with slow memory: FIFO fills, requests stop, then drain.
    setLatency(3, 3);
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("full_req_low", 32'(imem_req), 32'd0);
    checkOutput("full_head_pc", id_pc, RESET_PC);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Redirect while the fetch of 0x3008 is pending, ack two cycles later.
    setLatency(3, 3);
    doReset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found && imem_req && imem_addr == 32'h0000_3008 && memWait == 1) begin
        applyStimulus(1'b1, 1'b1, 32'h0040_0100);
        found = 1'b1;
        checkOutput("drop_flush_valid", 32'(id_valid), 32'd0);
        checkOutput("drop_old_addr", imem_addr, 32'h0000_3008);
      end else begin
        applyStimulus(1'b1, 1'b0, 32'd0);
      end
    end
    checkOutput("drop_scenario_hit", 32'(found), 32'd1);

    // Redirect coinciding with an ack: next request goes straight to the target.
    setLatency(0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0050_0000);
    checkOutput("same_ack_req", 32'(imem_req), 32'd1);
    checkOutput("same_ack_addr", imem_addr, 32'h0050_0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // PC wrap from 0xFFFF_FFFC to 0.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_first", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("wrap_next", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Misaligned redirect target.
    applyStimulus(1'b1, 1'b1, 32'h0040_0102);
`ifdef IF_ADEL_EN
    checkOutput("adel_req", 32'(imem_req), 32'd0);
    checkOutput("adel_valid", 32'(id_valid), 32'd1);
    checkOutput("adel_pc", id_pc, 32'h0040_0102);
    checkOutput("adel_flag", 32'(id_adel), 32'd1);
`else
    checkOutput("misalign_addr", imem_addr, 32'h0040_0100);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Random traffic: variable latency, back-pressure and redirects.
    setLatency(0, 3);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 2))
        0: tgt = $urandom;
        1: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: tgt = 32'h0040_0100 | 32'($urandom_range(0, 3));
      endcase
      applyStimulus($urandom_range(0, 3) != 0, r, tgt);
    end

    // Asynchronous reset in the middle of a request.
    setLatency(3, 3);
    doReset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found && imem_req && id_valid) found = 1'b1;
      else if (!found) applyStimulus(1'b0, 1'b0, 32'd0);
    end
    checkOutput("async_setup_hit", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_req_drop", 32'(imem_req), 32'd0);
    checkOutput("async_valid_drop", 32'(id_valid), 32'd0);
    imem_ack = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    setLatency(0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
